// File: rtl/cc_road_row_gen.sv
// cc_road_row_gen: screen-mode sequencer and LFSR road-row source for the 4:1 screen mux.
// Latency: all outputs are registered and change on the clock edge after the event is sampled.
// Backpressure: none. Ticks are consumed as they arrive; rows are offered once, with a rowValid pulse.
//
// Ports:
//   CC_ROWGEN_CLOCK_50       in   system clock, rising edge
//   CC_ROWGEN_RESET_InHigh   in   synchronous active-high reset
//   CC_ROWGEN_tick_In        in   one-clock game-tick pulse from the prescaler
//   CC_ROWGEN_start_In       in   start request, level sampled every clock
//   CC_ROWGEN_crash_In       in   collision flag from the game logic
//   CC_ROWGEN_select_OutBUS  out  mux select: 0 blank, 1 solid, 2 random (zero-extended)
//   CC_ROWGEN_data_OutBUS    out  current road row towards the mux data input
//   CC_ROWGEN_rowValid_Out   out  one-clock pulse when data_OutBUS takes a new row
//   CC_ROWGEN_state_OutBUS   out  FSM state code (0 IDLE, 1 FLASH, 2 PLAY, 3 OVER)
//
// Build option: define CC_ROWGEN_GAP_GUARD_EN to clear bit 0 of any all-ones candidate row,
// so that every row has at least one drivable gap. The LFSR sequence itself is not affected.

module cc_road_row_gen #(
  parameter int unsigned ROWGEN_DATAWIDTH   = 8,        // row width, must be <= 16
  parameter int unsigned ROWGEN_SELECTWIDTH = 8,        // mux select width
  parameter logic [15:0] ROWGEN_SEED        = 16'hACE1, // LFSR reset value (0 forced to 1)
  parameter int unsigned ROWGEN_FLASH_TICKS = 4,        // ticks spent in FLASH, 1..255
  parameter int unsigned ROWGEN_ROW_TICKS   = 8         // ticks between rows in PLAY, 1..255
) (
  input  logic                          CC_ROWGEN_CLOCK_50,
  input  logic                          CC_ROWGEN_RESET_InHigh,
  input  logic                          CC_ROWGEN_tick_In,
  input  logic                          CC_ROWGEN_start_In,
  input  logic                          CC_ROWGEN_crash_In,
  output logic [ROWGEN_SELECTWIDTH-1:0] CC_ROWGEN_select_OutBUS,
  output logic [ROWGEN_DATAWIDTH-1:0]   CC_ROWGEN_data_OutBUS,
  output logic                          CC_ROWGEN_rowValid_Out,
  output logic [1:0]                    CC_ROWGEN_state_OutBUS
);

  localparam int unsigned DW = ROWGEN_DATAWIDTH;
  localparam int unsigned SW = ROWGEN_SELECTWIDTH;

  // An all-zero Galois LFSR is stuck forever, so a zero seed is replaced.
  localparam logic [15:0] SEED_EFF  = (ROWGEN_SEED == 16'h0000) ? 16'h0001 : ROWGEN_SEED;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  // The counter compares against N-1 so the N-th tick is the one that fires.
  localparam logic [7:0] FLASH_LAST = 8'(ROWGEN_FLASH_TICKS - 1);
  localparam logic [7:0] ROW_LAST   = 8'(ROWGEN_ROW_TICKS - 1);

  localparam logic [DW-1:0] ROW_ZERO = '0;
  localparam logic [DW-1:0] ROW_ONES = '1;
  localparam logic [DW-1:0] ROW_BIT0 = DW'(1);

  localparam logic [SW-1:0] SEL_BLANK  = SW'(0);
  localparam logic [SW-1:0] SEL_SOLID  = SW'(1);
  localparam logic [SW-1:0] SEL_RANDOM = SW'(2);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLASH = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [SW-1:0]   select_q, select_d;
  logic [DW-1:0]   data_q, data_d;
  logic            row_vld_q, row_vld_d;

  logic [15:0]     lfsr_next;
  logic [DW-1:0]   row_raw;
  logic [DW-1:0]   row_cand;

  // Galois form, right shift: the bit falling out of position 0 folds the mask back in.
  assign lfsr_next = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
  assign row_raw   = lfsr_next[DW-1:0];

`ifdef CC_ROWGEN_GAP_GUARD_EN
  // A solid row would leave the player no way through; open a gap at bit 0.
  assign row_cand = (row_raw == ROW_ONES) ? (row_raw & ~ROW_BIT0) : row_raw;
`else
  assign row_cand = row_raw;
`endif

  // Next-state and next-output logic. Outputs are computed here and registered below,
  // so the outputs always reflect the state entered on the same edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lfsr_d    = lfsr_q;
    select_d  = select_q;
    data_d    = data_q;
    row_vld_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        select_d = SEL_BLANK;
        data_d   = ROW_ZERO;
        if (CC_ROWGEN_start_In) begin
          state_d  = ST_FLASH;
          cnt_d    = 8'd0;
          select_d = SEL_SOLID;
          data_d   = ROW_ONES;
        end
      end

      ST_FLASH: begin
        select_d = SEL_SOLID;
        data_d   = ROW_ONES;
        if (CC_ROWGEN_tick_In) begin
          if (cnt_q == FLASH_LAST) begin
            // Leaving the flash screen: the first road row is loaded on the same edge.
            state_d   = ST_PLAY;
            cnt_d     = 8'd0;
            lfsr_d    = lfsr_next;
            select_d  = SEL_RANDOM;
            data_d    = row_cand;
            row_vld_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end

      ST_PLAY: begin
        select_d = SEL_RANDOM;
        // Crash takes priority over a coinciding row load: no row, no LFSR step.
        if (CC_ROWGEN_crash_In) begin
          state_d  = ST_OVER;
          select_d = SEL_SOLID;
          data_d   = ROW_ONES;
        end else if (CC_ROWGEN_tick_In) begin
          if (cnt_q == ROW_LAST) begin
            cnt_d     = 8'd0;
            lfsr_d    = lfsr_next;
            data_d    = row_cand;
            row_vld_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end

      ST_OVER: begin
        select_d = SEL_SOLID;
        data_d   = ROW_ONES;
        // The LFSR is deliberately left running on from where it stopped,
        // so the next game gets a different road.
        if (CC_ROWGEN_start_In) begin
          state_d  = ST_IDLE;
          cnt_d    = 8'd0;
          select_d = SEL_BLANK;
          data_d   = ROW_ZERO;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        cnt_d    = 8'd0;
        select_d = SEL_BLANK;
        data_d   = ROW_ZERO;
      end
    endcase
  end

  always_ff @(posedge CC_ROWGEN_CLOCK_50) begin
    if (CC_ROWGEN_RESET_InHigh) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      lfsr_q    <= SEED_EFF;
      select_q  <= SEL_BLANK;
      data_q    <= ROW_ZERO;
      row_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lfsr_q    <= lfsr_d;
      select_q  <= select_d;
      data_q    <= data_d;
      row_vld_q <= row_vld_d;
    end
  end

  assign CC_ROWGEN_select_OutBUS = select_q;
  assign CC_ROWGEN_data_OutBUS   = data_q;
  assign CC_ROWGEN_rowValid_Out  = row_vld_q;
  assign CC_ROWGEN_state_OutBUS  = state_q;

endmodule
